// File: rtl/uart_core_param.sv
// Purpose: parametrised full-duplex UART with mid-bit RX sampling, framing/parity checks, one-entry RX hold.
// Latency: TX line moves the cycle after accept; RX word appears one cycle after the final stop-bit sample.
// Backpressure: tx_start ignored while tx_busy; an unread RX word is overwritten and flagged by rx_overrun.
module uart_core_param #(
  parameter int DIV       = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done,
  input  logic                 rx_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t              r_tx_state;
  logic [CW-1:0]          r_tx_cnt;
  logic [3:0]             r_tx_bit;
  logic                   r_tx_stop;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic                   r_tx_par;
  logic                   r_tx;
  logic                   r_tx_busy;
  logic                   r_tx_done;
  logic                   w_tx_tick;

  assign w_tx_tick = (r_tx_cnt == DIV_M1);
  assign tx        = r_tx;
  assign tx_busy   = r_tx_busy;
  assign tx_done   = r_tx_done;

  // TX FSM: each bit held for DIV cycles; the line level for the next bit is registered at the bit boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      if (r_tx_state != TX_IDLE) begin
        r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + CNT_ONE;
      end
      case (r_tx_state)
        TX_IDLE: begin
          r_tx <= 1'b1;
          if (tx_start) begin
            r_tx_shift <= tx_data;
            // odd parity inverts the plain XOR so data+parity carries an odd count of ones
            r_tx_par   <= (^tx_data) ^ ODD;
            r_tx       <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tick) begin
            r_tx       <= r_tx_shift[0];
            r_tx_bit   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tick) begin
            if (r_tx_bit == LAST_BIT) begin
              r_tx_stop <= 1'b0;
              if (HAS_PAR) begin
                r_tx       <= r_tx_par;
                r_tx_state <= TX_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_tx_state <= TX_STOP;
              end
            end else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_tx       <= r_tx_shift[1];
              r_tx_bit   <= r_tx_bit + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (w_tx_tick) begin
            r_tx       <= 1'b1;
            r_tx_stop  <= 1'b0;
            r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_tick) begin
            if (r_tx_stop == LAST_STOP) begin
              r_tx_busy  <= 1'b0;
              r_tx_done  <= 1'b1;
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_stop <= 1'b1;
            end
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic                 r_rx_s1;
  logic                 r_rx_s2;
  rx_state_t            r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [3:0]           r_rx_bit;
  logic                 r_rx_stop;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_pbit;
  logic                 r_rx_ferr_acc;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_ready;
  logic                 r_rx_ferr;
  logic                 r_rx_perr;
  logic                 r_rx_ovr;
  logic                 w_rx;
  logic                 w_rx_tick;
  logic                 w_frame_err;
  logic                 w_parity_err;

  assign w_rx         = r_rx_s2;
  assign w_rx_tick    = (r_rx_cnt == DIV_M1);
  // frame error covers any earlier stop bit plus the one being sampled now
  assign w_frame_err  = r_rx_ferr_acc | ~w_rx;
  assign w_parity_err = HAS_PAR & ((^r_rx_shift) ^ r_rx_pbit ^ ODD);

  assign rx_data       = r_rx_data;
  assign rx_ready      = r_rx_ready;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_parity_err = r_rx_perr;
  assign rx_overrun    = r_rx_ovr;

  // Two-flop synchroniser for the asynchronous serial input; idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // RX FSM plus holding register; a completing frame takes priority over a same-cycle ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state    <= RX_IDLE;
      r_rx_cnt      <= '0;
      r_rx_bit      <= '0;
      r_rx_stop     <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_pbit     <= 1'b0;
      r_rx_ferr_acc <= 1'b0;
      r_rx_data     <= '0;
      r_rx_ready    <= 1'b0;
      r_rx_ferr     <= 1'b0;
      r_rx_perr     <= 1'b0;
      r_rx_ovr      <= 1'b0;
    end else begin
      if (rx_ack && r_rx_ready) begin
        r_rx_ready <= 1'b0;
        r_rx_ovr   <= 1'b0;
      end
      if (!rx_enable) begin
        r_rx_state <= RX_IDLE;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!w_rx) begin
              // the detect cycle counts as the first cycle of the half-bit wait
              r_rx_cnt   <= CNT_ONE;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_rx_cnt == HALF_M1) begin
              r_rx_cnt <= '0;
              if (!w_rx) begin
                r_rx_bit      <= '0;
                r_rx_ferr_acc <= 1'b0;
                r_rx_state    <= RX_DATA;
              end else begin
                r_rx_state <= RX_IDLE;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
          end
          RX_DATA: begin
            if (w_rx_tick) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
              if (r_rx_bit == LAST_BIT) begin
                r_rx_stop  <= 1'b0;
                r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
              end else begin
                r_rx_bit <= r_rx_bit + 4'd1;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
          end
          RX_PARITY: begin
            if (w_rx_tick) begin
              r_rx_cnt   <= '0;
              r_rx_pbit  <= w_rx;
              r_rx_stop  <= 1'b0;
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
          end
          RX_STOP: begin
            if (w_rx_tick) begin
              r_rx_cnt <= '0;
              if (r_rx_stop == LAST_STOP) begin
                r_rx_data  <= r_rx_shift;
                r_rx_ready <= 1'b1;
                r_rx_ferr  <= w_frame_err;
                r_rx_perr  <= w_parity_err;
                r_rx_ovr   <= (r_rx_ready | r_rx_ovr) & ~rx_ack;
                // a low stop bit may be a break: hold off until the line recovers
                r_rx_state <= w_frame_err ? RX_WAIT_HIGH : RX_IDLE;
              end else begin
                r_rx_stop     <= 1'b1;
                r_rx_ferr_acc <= w_frame_err;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + CNT_ONE;
            end
          end
          RX_WAIT_HIGH: begin
            if (w_rx) r_rx_state <= RX_IDLE;
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core: the next generation of the bring-up UART.
- Supports configurable data width, parity, stop bits and baud divisor.
- Adds mid-bit RX sampling with start-bit glitch rejection, framing/parity error detection, and a one-entry RX holding register with an overrun flag.
- Sits between the bring-up CPU/bus glue and the board serial pins.

Parameters:
- DIV, 868, clk cycles per bit (range 4..65535; 868 = 100 MHz / 115200).
- DATA_BITS, 8, data bits per frame (range 5..9).
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- tx_data  input  DATA_BITS  word to transmit; sampled only on the accept cycle.
- tx_start  input  1  transmit request; accepted when tx_busy=0.
- tx  output  1  serial out; idles high.
- tx_busy  output  1  high while a frame is being sent.
- tx_done  output  1  one-cycle pulse at end of frame.
- rx_enable  input  1  receiver enable.
- rx  input  1  asynchronous serial in.
- rx_data  output  DATA_BITS  last received word.
- rx_ready  output  1  level; rx_data holds an unread word.
- rx_ack  input  1  consumer has read rx_data; clears rx_ready and rx_overrun.
- rx_frame_err  output  1  a stop bit of the last frame was sampled 0.
- rx_parity_err  output  1  parity mismatch on the last frame; always 0 when PARITY=0.
- rx_overrun  output  1  sticky; a frame completed while rx_ready=1.

Behaviour:
- Reset (reset=0, async): tx=1; tx_busy, tx_done, rx_ready, all error flags = 0; rx_data=0; both FSMs IDLE; rx synchroniser flops = 1.
- Bit timer: each bit period is exactly DIV cycles, counted with a clog2(DIV)-bit counter.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - tx_start with tx_busy=0 latches tx_data. tx goes 0 and tx_busy goes 1 on the next cycle.
  - Data is sent LSB first, then the parity bit if PARITY!=0, then STOP_BITS stop bits of 1.
  - Odd parity: the parity bit makes the total count of 1s in data+parity odd. Even parity: makes it even.
  - After the last stop-bit cycle: tx_busy=0 and tx_done=1 for one cycle, FSM back in IDLE.
  - A tx_start in that same cycle is accepted. tx_start while tx_busy=1 is ignored.
  - Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV cycles.
- RX input: rx passes through a 2-flop synchroniser (2 cycles latency). All RX decisions use the synchronised value.
- RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
  - IDLE: wait for rx_enable=1 and a synchronised falling level (0).
  - START: count DIV/2 cycles. If the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA/PARITY/STOP: sample once every DIV cycles (mid-bit), shift in LSB first.
  - Any stop bit sampled 0 sets the frame error. After the final stop sample, the frame completes even on error.
  - On frame error, enter WAIT_HIGH until the line is 1 (break handling), then go to IDLE. Otherwise return to IDLE directly.
- Frame completion (single cycle):
  - rx_data is updated and rx_ready=1.
  - rx_frame_err and rx_parity_err are loaded with this frame's status.
  - If rx_ready was already 1 and rx_ack=0, set rx_overrun=1; the new data overwrites the old.
- rx_ack:
  - Clears rx_ready and rx_overrun on the next edge.
  - rx_ack in the same cycle as a frame completion: the new frame wins; rx_ready stays 1 and rx_overrun is not set.
  - rx_ack with rx_ready=0 has no effect.
- Error flags hold until the next frame completes or reset.
- rx_enable=0 mid-frame: abort to IDLE immediately, no completion and no flag change. rx_enable=0 does not clear an already-held word.
- TX and RX are fully independent; loopback (tx tied to rx) must work.
- Reset asserted mid-frame on either side: immediate return to reset values; tx driven 1 within the same reset assertion.

Test Plan:
- TX 8N1, DIV=4, tx_data=8'hA5: tx_start pulse at cycle T.
  - Expected tx from T+1: 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles.
  - tx_busy=1 for T+1..T+40; tx_done=1 only at T+41.
- TX 8E2, DIV=4, 8'hA5: parity bit 0, then two stop bits of 1; tx_done at T+49. Same with odd parity: parity bit 1.
- RX loopback 8N1, DIV=4:
  - Send 8'h3C: rx_ready rises, rx_data=8'h3C, both error flags 0.
  - rx_ack -> rx_ready=0 next cycle.
  - Send 8'h3C, no ack, then 8'hC3: rx_data=8'hC3, rx_overrun=1. rx_ack clears both.
- Glitch and framing, DIV=8:
  - Drive rx low for 2 cycles: no state change, rx_ready stays 0.
  - Send 8'h55 with stop bit forced 0: rx_ready=1, rx_frame_err=1.
  - Next start bit is ignored until the line returns high.
- Parity error 8O1: inject a frame with the wrong parity bit for 8'h0F -> rx_parity_err=1, rx_data=8'h0F.
- Reset and abort:
  - Assert reset mid-TX: tx=1 and tx_busy=0 while reset=0.
  - Drop rx_enable mid-RX frame: no rx_ready.
  - Re-enable and send a clean frame: received correctly.
